mp_addsub_iter: RTL

//  Parametrised iterative multi-precision adder/subtractor: computes A+B or A-B on

---
 rtl/mp_pkg.sv | 25 ++
 rtl/mp_addsub_iter_if.sv | 36 +++
 rtl/mp_word_adder.sv | 22 ++
 rtl/mp_addsub_iter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// ---------------------------------------------------------------------------
// mp_pkg
// Shared definitions for the multi-precision arithmetic slice: default
// operand and word widths, the controller state encoding and a helper that
// sizes the word counter.
// ---------------------------------------------------------------------------
package mp_pkg;

    localparam int MP_OPERAND_WIDTH = 1024;
    localparam int MP_WORD_WIDTH    = 64;

    // Encoding 2'd3 is never entered; the controller steers it back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_e;

    // Counter width for a given number of words; never narrower than one bit
    // so the single-word configuration still has a legal counter.
    function automatic int mp_cnt_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/mp_addsub_iter_if.sv
// ---------------------------------------------------------------------------
// mp_addsub_iter_if
// Start/done request bus of the iterative adder/subtractor.
//   start     request; only taken when the engine is not busy
//   subtract  0: A+B, 1: A-B (sampled with start)
//   in_a/in_b operands (sampled with start)
//   result    {carry/borrow, sum}; valid while done is high and held after
//   done      one-cycle completion pulse
//   busy      high while words are being processed
// master: the requester; slave: the arithmetic engine.
// ---------------------------------------------------------------------------
interface mp_addsub_iter_if
    import mp_pkg::*;
#(
    parameter int OPERAND_WIDTH = MP_OPERAND_WIDTH
);

    logic                     start;
    logic                     subtract;
    logic [OPERAND_WIDTH-1:0] in_a;
    logic [OPERAND_WIDTH-1:0] in_b;
    logic [OPERAND_WIDTH:0]   result;
    logic                     done;
    logic                     busy;

    modport master (
        output start, subtract, in_a, in_b,
        input  result, done, busy
    );

    modport slave (
        input  start, subtract, in_a, in_b,
        output result, done, busy
    );

endinterface

// File: rtl/mp_word_adder.sv
// ---------------------------------------------------------------------------
// mp_word_adder
// Combinational single-word adder slice: {cout, sum} = a + b + cin.
//   a, b  WORD_WIDTH-bit addends
//   cin   carry in
//   sum   WORD_WIDTH-bit sum
//   cout  carry out
// ---------------------------------------------------------------------------
module mp_word_adder #(
    parameter int WORD_WIDTH = 64
) (
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  cout
);

    // Every term is widened to WORD_WIDTH+1 so the carry lands in the top bit.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mp_addsub_iter.sv
// ---------------------------------------------------------------------------
// mp_addsub_iter
// Iterative multi-precision adder/subtractor. Processes one WORD_WIDTH-bit
// word per clock, least significant word first, carrying through a register.
// Subtraction is A + ~B + 1; the final top bit is the carry for add and the
// borrow (inverted carry) for subtract.
//   clk     rising-edge clock
//   resetn  synchronous, active-low reset
//   bus     request interface (slave side): start/subtract/in_a/in_b in,
//           result/done/busy out
// ---------------------------------------------------------------------------
module mp_addsub_iter
    import mp_pkg::*;
#(
    parameter int OPERAND_WIDTH = MP_OPERAND_WIDTH,
    parameter int WORD_WIDTH    = MP_WORD_WIDTH
) (
    input  logic              clk,
    input  logic              resetn,
    mp_addsub_iter_if.slave   bus
);

    localparam int NWORDS = OPERAND_WIDTH / WORD_WIDTH;
    localparam int CNT_W  = mp_cnt_width(NWORDS);

    mp_state_e                state_q;
    mp_state_e                state_d;
    logic                     accept;
    logic                     last_word;

    logic [OPERAND_WIDTH-1:0] op_a_q;
    logic [OPERAND_WIDTH-1:0] op_b_q;
    logic                     sub_q;
    logic                     carry_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [OPERAND_WIDTH:0]   res_q;

    logic [WORD_WIDTH-1:0]    b_word;
    logic                     cin;
    logic [WORD_WIDTH-1:0]    sum;
    logic                     cout;
    logic [OPERAND_WIDTH+WORD_WIDTH-1:0] res_shift;

    assign last_word = (cnt_q == CNT_W'(NWORDS - 1));

    // The first word takes the subtract flag as carry-in, which supplies the
    // +1 of the two's complement; later words chain the registered carry.
    assign b_word = sub_q ? ~op_b_q[WORD_WIDTH-1:0] : op_b_q[WORD_WIDTH-1:0];
    assign cin    = (cnt_q == '0) ? sub_q : carry_q;

    mp_word_adder #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_word_adder (
        .a    (op_a_q[WORD_WIDTH-1:0]),
        .b    (b_word),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    // New sum words enter at the top of the result and the whole result
    // drifts down one word per cycle, so after NWORDS cycles word 0 sits at
    // the bottom.
    assign res_shift = {sum, res_q[OPERAND_WIDTH-1:0]};

    // State register; reset lands in IDLE which also aborts any operation.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A start seen in DONE is accepted just like in IDLE so
    // consecutive operations run without a gap cycle; start during RUN is
    // ignored.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured on an accepted start so the inputs may
    // change afterwards; in RUN both operand registers shift down one word,
    // the result shifts in the new sum word, and the last word also writes
    // the carry/borrow bit. Outside RUN the result simply holds.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (accept) begin
            op_a_q  <= bus.in_a;
            op_b_q  <= bus.in_b;
            sub_q   <= bus.subtract;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            op_a_q  <= op_a_q >> WORD_WIDTH;
            op_b_q  <= op_b_q >> WORD_WIDTH;
            carry_q <= cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            res_q[OPERAND_WIDTH-1:0] <= res_shift[OPERAND_WIDTH+WORD_WIDTH-1:WORD_WIDTH];
            if (last_word) begin
                res_q[OPERAND_WIDTH] <= sub_q ? ~cout : cout;
            end
        end
    end

    assign bus.result = res_q;
    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);

endmodule
